// File: rtl/matrix_reduce_pkg.sv
// Shared types for the streaming matrix row reducer.
package matrix_reduce_pkg;

   typedef enum logic [1:0] {
      OP_OR  = 2'b00,
      OP_AND = 2'b01,
      OP_XOR = 2'b10,
      OP_RSV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_HOLD
   } state_e;

   // The reserved encoding behaves as OR and is reported as OR.
   function automatic op_e op_norm(op_e op);
      return (op == OP_RSV) ? OP_OR : op;
   endfunction

endpackage

// File: rtl/matrix_reduce_op.sv
// Combinational bitwise fold of two rows under the selected reduction op.
module matrix_reduce_op
   import matrix_reduce_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = a | b;
      unique case (op)
         OP_AND:  y = a & b;
         OP_XOR:  y = a ^ b;
         default: y = a | b;
      endcase
   end

endmodule

// File: rtl/matrix_reduce_stream.sv
// Streaming row reducer: folds up to ROWS rows per frame into one WIDTH-bit word
// and holds the result until the downstream handshake.
module matrix_reduce_stream
   import matrix_reduce_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ROWS  = 16,
   parameter int unsigned CNT_W = $clog2(ROWS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       op_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_rows,
   output logic [1:0]       out_op
);

   localparam logic [CNT_W-1:0] RowsMax = CNT_W'(ROWS);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
   op_e              op_lat_q, op_lat_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] out_rows_q, out_rows_d;
   logic [1:0]       out_op_q, out_op_d;

   logic [WIDTH-1:0] fold;
   logic [CNT_W-1:0] cnt_inc;
   logic             row_accept, row_first, row_next, frame_done, out_hs;

   matrix_reduce_op #(
      .WIDTH(WIDTH)
   ) u_op (
      .a (acc_q),
      .b (in_data),
      .op(op_lat_q),
      .y (fold)
   );

   assign cnt_inc    = row_cnt_q + CntOne;
   assign out_hs     = out_valid_q & out_ready;
   assign row_accept = in_valid & in_ready;
   // A first row can arrive in IDLE or in HOLD on the same cycle the result leaves.
   assign row_first  = row_accept & ((state_q == S_IDLE) | (state_q == S_HOLD));
   assign row_next   = row_accept & (state_q == S_ACCUM);
   assign frame_done = row_next & (in_last | (cnt_inc == RowsMax));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (row_first) state_d = in_last ? S_HOLD : S_ACCUM;
         S_ACCUM: if (frame_done) state_d = S_HOLD;
         S_HOLD: begin
            if (out_hs) begin
               if (row_first) state_d = in_last ? S_HOLD : S_ACCUM;
               else           state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = ~rst & ((state_q != S_HOLD) | out_ready);
   end

   always_comb begin
      acc_d       = acc_q;
      row_cnt_d   = row_cnt_q;
      op_lat_d    = op_lat_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_rows_d  = out_rows_q;
      out_op_d    = out_op_q;
      if (out_hs) out_valid_d = 1'b0;
      if (row_first) begin
         acc_d     = in_data;
         row_cnt_d = CntOne;
         op_lat_d  = op_e'(op_mode);
         if (in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_rows_d  = CntOne;
            out_op_d    = op_norm(op_e'(op_mode));
         end
      end else if (row_next) begin
         acc_d     = fold;
         row_cnt_d = cnt_inc;
         if (frame_done) begin
            out_valid_d = 1'b1;
            out_data_d  = fold;
            out_rows_d  = cnt_inc;
            out_op_d    = op_norm(op_lat_q);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         row_cnt_q   <= '0;
         op_lat_q    <= OP_OR;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_rows_q  <= '0;
         out_op_q    <= 2'b00;
      end else begin
         acc_q       <= acc_d;
         row_cnt_q   <= row_cnt_d;
         op_lat_q    <= op_lat_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_rows_q  <= out_rows_d;
         out_op_q    <= out_op_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_rows  = out_rows_q;
   assign out_op    = out_op_q;

endmodule

// File: tb/tb_matrix_reduce_stream.sv
// Scoreboard bench for matrix_reduce_stream: a frame-level reference model queues
// expected results, and an independent monitor checks every output handshake.
module tb_matrix_reduce_stream;

   localparam int WIDTH = 16;
   localparam int ROWS  = 16;
   localparam int CNT_W = 5;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [CNT_W-1:0] rows;
      logic [1:0]       op;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       op_mode = 2'b00;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] out_rows;
   logic [1:0]       out_op;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

   exp_t             exp_q[$];
   logic [WIDTH-1:0] fr_rows[$];
   logic [1:0]       fr_op;
   bit               due[int];

   logic             hold_prev = 1'b0;
   exp_t             prev_out;

   matrix_reduce_stream #(
      .WIDTH(WIDTH),
      .ROWS (ROWS),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .op_mode  (op_mode),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_rows (out_rows),
      .out_op   (out_op)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: collect a frame's rows, reduce the whole list when it closes.
   task automatic model_accept(input logic [WIDTH-1:0] d, input logic last,
                               input logic [1:0] op);
      exp_t e;
      logic [WIDTH-1:0] r;
      if (fr_rows.size() == 0) fr_op = (op == 2'b11) ? 2'b00 : op;
      fr_rows.push_back(d);
      if (last || fr_rows.size() == ROWS) begin
         r = fr_rows[0];
         for (int i = 1; i < fr_rows.size(); i++) begin
            case (fr_op)
               2'b01:   r = r & fr_rows[i];
               2'b10:   r = r ^ fr_rows[i];
               default: r = r | fr_rows[i];
            endcase
         end
         e.data = r;
         e.rows = CNT_W'(fr_rows.size());
         e.op   = fr_op;
         exp_q.push_back(e);
         fr_rows.delete();
         due[cyc + 1] = 1'b1;
      end
   endtask

   task automatic set_ready();
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_data = WIDTH'($urandom);
         set_ready();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_row(input logic [WIDTH-1:0] d, input logic last, input logic [1:0] op,
                           input bit no_stall);
      int waits = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      op_mode  = op;
      forever begin
         set_ready();
         @(negedge clk);
         if (in_ready) break;
         waits++;
         if (waits > 500) begin
            check("row_accept_timeout", 32'(waits), 32'd0);
            break;
         end
         @(posedge clk);
         #1;
      end
      if (no_stall) check("row_no_stall", 32'(waits), 32'd0);
      if (in_ready) model_accept(d, last, op);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = WIDTH'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      ready_mode = 1;
      in_valid   = 1'b0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         idle(1);
         n++;
      end
      check("drain_complete", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: compare results at handshakes and check stability under backpressure.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_prev <= 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_out.data));
            check("hold_rows", 32'(out_rows), 32'(prev_out.rows));
            check("hold_op", 32'(out_op), 32'(prev_out.op));
         end
         if (out_valid && !out_ready) check("hold_in_ready", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(e.data));
               check("out_rows", 32'(out_rows), 32'(e.rows));
               check("out_op", 32'(out_op), 32'(e.op));
            end
         end
         if (due.exists(cyc)) begin
            check("result_latency", 32'(out_valid), 32'd1);
            due.delete(cyc);
         end
         hold_prev     <= out_valid && !out_ready;
         prev_out.data <= out_data;
         prev_out.rows <= out_rows;
         prev_out.op   <= out_op;
      end
   end

   initial begin
      int len;
      logic [1:0] op;
      // Reset values
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_rows", 32'(out_rows), 32'd0);
      check("rst_out_op", 32'(out_op), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // 1. Full 16-row OR frame of one-hot rows
      ready_mode = 1;
      for (int i = 0; i < ROWS; i++) send_row(WIDTH'(1 << i), 1'b0, 2'b00, 1'b1);
      drain();

      // 2. Short AND frame; op change mid-frame ignored
      send_row(16'hF0F3, 1'b0, 2'b01, 1'b1);
      send_row(16'hFF31, 1'b0, 2'b10, 1'b1);
      send_row(16'h70FF, 1'b1, 2'b01, 1'b1);
      drain();

      // 3. XOR with 5 cycles of backpressure, then restart on the handshake cycle
      ready_mode = 0;
      send_row(16'hAAAA, 1'b0, 2'b10, 1'b1);
      send_row(16'h5555, 1'b0, 2'b10, 1'b1);
      send_row(16'h0F0F, 1'b1, 2'b10, 1'b1);
      idle(5);
      ready_mode = 1;
      // 4. Back-to-back 2-row frames, first row lands on the pending result's handshake
      for (int f = 0; f < 6; f++) begin
         op = (f % 2 == 0) ? 2'b00 : 2'b10;
         send_row(WIDTH'($urandom), 1'b0, op, 1'b1);
         send_row(WIDTH'($urandom), 1'b1, op, 1'b1);
      end
      drain();

      // 5. Single row with reserved op
      send_row(16'h1234, 1'b1, 2'b11, 1'b1);
      drain();

      // 6. Reset mid-frame discards the partial frame
      for (int i = 0; i < 7; i++) send_row(WIDTH'($urandom), 1'b0, 2'b01, 1'b1);
      rst = 1'b1;
      fr_rows.delete();
      due.delete();
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(3);
      for (int i = 0; i < ROWS; i++) send_row(16'h0001, 1'b0, 2'b00, 1'b1);
      drain();

      // Randomized frames with random gaps and backpressure
      ready_mode = 2;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, ROWS);
         op  = 2'($urandom);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_row(WIDTH'($urandom),
                     (i == len - 1) && (len < ROWS || $urandom_range(0, 1) == 1),
                     (i == 0) ? op : 2'($urandom), 1'b0);
         end
      end
      drain();
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1);
   end

endmodule
